// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
//   Shared configuration and types for the SoC change-trace recorder.
//   The channel count, data width, FIFO depth and timestamp width are fixed
//   here so that the FIFO entry struct, the output interface and the bench all
//   agree on one set of widths.
//   Optional feature macro: TRACE_TIMESTAMP_EN. When it is defined, each entry
//   carries a TS_W-bit timestamp. When it is undefined, the ts field is absent
//   from the entry.
// -----------------------------------------------------------------------------
package trace_pkg;

  localparam int NUM_CH = 5;   // probe channels (1..16)
  localparam int DATA_W = 32;  // width of each channel
  localparam int DEPTH  = 16;  // FIFO entries (power of two, >= 2)
  localparam int TS_W   = 16;  // timestamp counter width

  // $clog2(NUM_CH), kept at least 1 bit wide so a single-channel build still
  // has a legal out_ch port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [7:0] DROP_SAT = 8'hFF;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/soc_trace_recorder_if.sv
// -----------------------------------------------------------------------------
// soc_trace_recorder_if
//   Valid/ready drain port of the trace recorder.
//   master: recorder side  (drives out_valid/out_ch/out_data/out_ts, reads out_ready)
//   slave : consumer side  (reads the entry fields, drives out_ready)
// -----------------------------------------------------------------------------
interface soc_trace_recorder_if;
  import trace_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;

  modport master (output out_valid, out_ch, out_data, out_ts, input  out_ready);
  modport slave  (input  out_valid, out_ch, out_data, out_ts, output out_ready);

endinterface

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
//   Synchronous circular FIFO of trace_entry_t, DEPTH entries.
//   Pointers carry an extra wrap bit so full and empty are told apart without
//   a separate counter; count is the pointer difference.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     clear           synchronous flush, wins over wr_en/rd_en
//     wr_en, wr_data  push request; accepted when not full or when a pop
//                     happens in the same cycle
//     rd_en           pop request; ignored while empty
//     rd_data         head entry, all zero while empty
//     empty, full     status
//     count           entries stored
// -----------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  trace_entry_t     wr_data,
  input  logic             rd_en,
  output trace_entry_t     rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_wr, do_rd;
  trace_entry_t mem_q [DEPTH];

  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en && !empty && !clear;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // still accepts the push.
    do_wr    = wr_en && (!full || do_rd) && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents are only observed
  // through rd_data, which is forced to zero while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/soc_trace_recorder.sv
// -----------------------------------------------------------------------------
// soc_trace_recorder
//   Watches NUM_CH probe channels and queues one {timestamp, channel, value}
//   entry per detected change into a FIFO drained over a valid/ready port.
//   Only one channel is serviced per cycle, chosen by fixed priority with the
//   lowest index first. Other changed channels retry next cycle against their
//   then-current value, so their intermediate values are not recorded.
//   Optional feature macro: TRACE_TIMESTAMP_EN. When it is defined, a
//   free-running TS_W counter is built and out_ts carries the push-cycle
//   timestamp. When it is undefined, there is no counter and out_ts is 0.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     en         1 = detect/record changes; 0 = freeze detection (drain works)
//     clear      synchronous flush: empties FIFO, re-arms channels, clears flags
//     ch_data    channel i at [i*DATA_W +: DATA_W]
//     out_if     drain port (out_valid/out_ready/out_ch/out_data/out_ts)
//     count      entries stored
//     overflow   sticky: an entry was dropped because the FIFO was full
//     drop_cnt   dropped entries, saturating at 255
// -----------------------------------------------------------------------------
module soc_trace_recorder
  import trace_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  soc_trace_recorder_if.master     out_if,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  logic [NUM_CH-1:0][DATA_W-1:0] last_logged_q, last_logged_d;
  logic                          overflow_q, overflow_d;
  logic [7:0]                    drop_cnt_q, drop_cnt_d;
  logic                          push_req, wr_en, drop;
  logic                          fifo_empty, fifo_full;
  trace_entry_t                  push_entry, head_entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running, ignores en and clear, wraps naturally.
  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`endif

  // Change detect and priority select. The first differing channel found in
  // ascending order claims the single push slot of this cycle. Its last_logged
  // copy updates even if the FIFO later drops the entry, so it is not retried.
  always_comb begin
    push_req      = 1'b0;
    push_entry    = '0;
    last_logged_d = last_logged_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && !push_req &&
          (ch_data[i*DATA_W +: DATA_W] != last_logged_q[i])) begin
        push_req         = 1'b1;
        push_entry.ch    = CH_W'(i);
        push_entry.data  = ch_data[i*DATA_W +: DATA_W];
        last_logged_d[i] = ch_data[i*DATA_W +: DATA_W];
      end
    end
`ifdef TRACE_TIMESTAMP_EN
    push_entry.ts = ts_q;
`endif
    // All-ones re-arms every channel: the next enabled cycle logs each one.
    if (clear) last_logged_d = '1;
  end

  assign wr_en = push_req && !clear;
  // Full with no pop this cycle: the entry is lost and accounted for.
  assign drop  = wr_en && fifo_full && !out_if.out_ready;

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != DROP_SAT)) drop_cnt_d = drop_cnt_q + 8'd1;
    if (clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_logged_q <= '1;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      last_logged_q <= last_logged_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  trace_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_data (push_entry),
    .rd_en   (out_if.out_ready),
    .rd_data (head_entry),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_ch    = head_entry.ch;
  assign out_if.out_data  = head_entry.data;
`ifdef TRACE_TIMESTAMP_EN
  assign out_if.out_ts    = head_entry.ts;
`else
  assign out_if.out_ts    = '0;
`endif

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_soc_trace_recorder.sv
// -----------------------------------------------------------------------------
// tb_soc_trace_recorder
//   Directed bench for soc_trace_recorder. Inputs change on the falling edge,
//   and outputs are sampled on the falling edge before new stimulus is applied.
//   tb_ts mirrors the free-running timestamp so that expected out_ts values
//   come from the bench, not the DUT.
// -----------------------------------------------------------------------------
module tb_soc_trace_recorder;
  import trace_pkg::*;

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic                     clear;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [CNT_W-1:0]         count;
  logic                     overflow;
  logic [7:0]               drop_cnt;
  logic [TS_W-1:0]          tb_ts;

  int passed = 0;
  int total  = 0;

  soc_trace_recorder_if out_if ();

  soc_trace_recorder dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (clear),
    .ch_data  (ch_data),
    .out_if   (out_if),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + TS_W'(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [TS_W-1:0] exp_ts(input logic [TS_W-1:0] t);
`ifdef TRACE_TIMESTAMP_EN
    return t;
`else
    return '0;
`endif
  endfunction

  task automatic set_ch(input int i, input logic [DATA_W-1:0] v);
    ch_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clear = 1'b0; out_if.out_ready = 1'b0; ch_data = '0;
    repeat (2) @(negedge clk);
    total++; if (out_if.out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_if.out_valid); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL reset_flags: overflow %0b drop %0d want 0/0", overflow, drop_cnt); else passed++;
    total++; if (out_if.out_ch !== '0 || out_if.out_data !== '0 || out_if.out_ts !== '0)
      $display("FAIL reset_head: ch %0d data %h ts %0d want 0/0/0", out_if.out_ch, out_if.out_data, out_if.out_ts); else passed++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (count !== CNT_W'(5)) $display("FAIL initial_log_count: got %0d want 5", count); else passed++;
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (out_if.out_valid !== 1'b1 || out_if.out_ch !== CH_W'(k) || out_if.out_data !== '0)
        $display("FAIL initial_log_entry%0d: valid %0b ch %0d data %h want 1/%0d/0", k, out_if.out_valid, out_if.out_ch, out_if.out_data, k); else passed++;
      total++; if (out_if.out_ts !== exp_ts(TS_W'(k)))
        $display("FAIL initial_log_ts%0d: got %0d want %0d", k, out_if.out_ts, exp_ts(TS_W'(k))); else passed++;
      @(negedge clk);
    end
    total++; if (out_if.out_valid !== 1'b0 || count !== '0) $display("FAIL initial_drained: valid %0b count %0d want 0/0", out_if.out_valid, count); else passed++;
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_single_change();
    logic [TS_W-1:0] t;
    out_if.out_ready = 1'b1;
    set_ch(2, 32'h0000_0004);
    t = tb_ts;
    @(negedge clk);
    total++; if (out_if.out_valid !== 1'b1 || out_if.out_ch !== CH_W'(2) || out_if.out_data !== 32'h4)
      $display("FAIL single_entry: valid %0b ch %0d data %h want 1/2/4", out_if.out_valid, out_if.out_ch, out_if.out_data); else passed++;
    total++; if (out_if.out_ts !== exp_ts(t)) $display("FAIL single_ts: got %0d want %0d", out_if.out_ts, exp_ts(t)); else passed++;
    @(negedge clk);
    total++; if (out_if.out_valid !== 1'b0 || count !== '0) $display("FAIL single_only_one: valid %0b count %0d want 0/0", out_if.out_valid, count); else passed++;
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_if.out_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      set_ch(0, (j % 2 == 0) ? 32'h1 : 32'h0);
      @(negedge clk);
      if (j == 15) begin
        total++; if (count !== CNT_W'(16) || overflow !== 1'b0)
          $display("FAIL fill_exact: count %0d overflow %0b want 16/0", count, overflow); else passed++;
      end
    end
    total++; if (count !== CNT_W'(16)) $display("FAIL overflow_count: got %0d want 16", count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL overflow_flag: got %0b want 1", overflow); else passed++;
    total++; if (drop_cnt !== 8'd4) $display("FAIL overflow_drop_cnt: got %0d want 4", drop_cnt); else passed++;
    total++; if (out_if.out_ch !== '0 || out_if.out_data !== 32'h1)
      $display("FAIL overflow_head: ch %0d data %h want 0/1", out_if.out_ch, out_if.out_data); else passed++;
  endtask

  task automatic test_full_push_pop();
    out_if.out_ready = 1'b1;
    set_ch(1, 32'h0000_0055);
    @(negedge clk);
    total++; if (count !== CNT_W'(16) || drop_cnt !== 8'd4)
      $display("FAIL full_push_pop: count %0d drop %0d want 16/4", count, drop_cnt); else passed++;
    total++; if (out_if.out_data !== 32'h0) $display("FAIL full_pop_advance: data %h want 0", out_if.out_data); else passed++;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        total++; if (out_if.out_ch !== CH_W'(1) || out_if.out_data !== 32'h55)
          $display("FAIL full_pushed_tail: ch %0d data %h want 1/55", out_if.out_ch, out_if.out_data); else passed++;
      end
      @(negedge clk);
    end
    total++; if (out_if.out_valid !== 1'b0 || overflow !== 1'b1)
      $display("FAIL drain_sticky: valid %0b overflow %0b want 0/1", out_if.out_valid, overflow); else passed++;
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [TS_W-1:0] t;
    out_if.out_ready = 1'b0;
    set_ch(0, 32'h0000_000A);
    set_ch(3, 32'h0000_000B);
    t = tb_ts;
    @(negedge clk);
    total++; if (count !== CNT_W'(1)) $display("FAIL priority_one_per_cycle: count %0d want 1", count); else passed++;
    @(negedge clk);
    total++; if (count !== CNT_W'(2)) $display("FAIL priority_retry: count %0d want 2", count); else passed++;
    total++; if (out_if.out_ch !== '0 || out_if.out_data !== 32'hA || out_if.out_ts !== exp_ts(t))
      $display("FAIL priority_first: ch %0d data %h ts %0d want 0/a/%0d", out_if.out_ch, out_if.out_data, out_if.out_ts, exp_ts(t)); else passed++;
    out_if.out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_if.out_ch !== CH_W'(3) || out_if.out_data !== 32'hB || out_if.out_ts !== exp_ts(t + TS_W'(1)))
      $display("FAIL priority_second: ch %0d data %h ts %0d want 3/b/%0d", out_if.out_ch, out_if.out_data, out_if.out_ts, exp_ts(t + TS_W'(1))); else passed++;
    @(negedge clk);
    total++; if (out_if.out_valid !== 1'b0) $display("FAIL priority_drained: valid %0b want 0", out_if.out_valid); else passed++;
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_disable_clear();
    logic [DATA_W-1:0] exp_data [NUM_CH];
    exp_data = '{32'hA, 32'h77, 32'h4, 32'hB, 32'h0};
    en = 1'b0;
    set_ch(1, 32'h0000_0077);
    repeat (3) @(negedge clk);
    total++; if (count !== '0 || out_if.out_valid !== 1'b0)
      $display("FAIL disabled_no_push: count %0d valid %0b want 0/0", count, out_if.out_valid); else passed++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (count !== '0 || overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL clear_state: count %0d overflow %0b drop %0d want 0/0/0", count, overflow, drop_cnt); else passed++;
    en = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (count !== CNT_W'(5)) $display("FAIL rearm_count: got %0d want 5", count); else passed++;
    out_if.out_ready = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      total++; if (out_if.out_ch !== CH_W'(k) || out_if.out_data !== exp_data[k])
        $display("FAIL rearm_entry%0d: ch %0d data %h want %0d/%h", k, out_if.out_ch, out_if.out_data, k, exp_data[k]); else passed++;
      @(negedge clk);
    end
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    set_ch(4, 32'h0000_000C);
    @(negedge clk);
    total++; if (count !== CNT_W'(1)) $display("FAIL pre_reset_push: count %0d want 1", count); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (out_if.out_valid !== 1'b0 || count !== '0 || out_if.out_data !== '0)
      $display("FAIL async_reset: valid %0b count %0d data %h want 0/0/0", out_if.out_valid, count, out_if.out_data); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (count !== CNT_W'(5) || out_if.out_ch !== '0 || out_if.out_data !== 32'hA || out_if.out_ts !== '0)
      $display("FAIL post_reset_relog: count %0d ch %0d data %h ts %0d want 5/0/a/0", count, out_if.out_ch, out_if.out_data, out_if.out_ts); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_change();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_disable_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
